// File: rtl/mac_accum_signed_8bit.sv
// mac_accum_signed_8bit: signed 8x8 multiply with saturating frame accumulation.
// Ports: clk, rst (async, high), clear (sync abort), a/b + in_valid/in_ready (operand stream),
//        acc_out + out_valid/out_ready (frame sum), overflow (sticky saturation), count (beats taken).
module mult_signed_8bit (
  input  logic signed [7:0]  a,
  input  logic signed [7:0]  b,
  output logic signed [15:0] p
);
  assign p = 16'(a) * 16'(b);
endmodule

module mac_accum_signed_8bit #(
  parameter int LEN   = 8,
  parameter int ACC_W = 24,
  parameter int CNT_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic signed [7:0]       a,
  input  logic signed [7:0]       b,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [ACC_W-1:0] acc_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overflow,
  output logic [CNT_W-1:0]        count
);
  typedef enum logic [1:0] {ACC, DRAIN, HOLD} state_t;
  state_t                  r_state;
  logic signed [ACC_W-1:0] r_acc, r_prod;
  logic                    r_pv, r_ovf;
  logic [CNT_W-1:0]        r_cnt;
  logic signed [15:0]      w_prod;
  logic signed [ACC_W-1:0] w_ext, w_next;
  logic signed [ACC_W:0]   w_sum;
  logic                    w_beat, w_sat;

  mult_signed_8bit u_mult (.a(a), .b(b), .p(w_prod));

  assign w_ext  = ACC_W'(w_prod);
  assign w_beat = in_valid && (r_state == ACC);
  // One guard bit: sum overflowed iff the top two bits disagree; the guard bit gives the true sign.
  assign w_sum  = (ACC_W+1)'(r_acc) + (ACC_W+1)'(r_prod);
  assign w_sat  = w_sum[ACC_W] != w_sum[ACC_W-1];
  assign w_next = w_sat ? (w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}})
                        : w_sum[ACC_W-1:0];

  assign in_ready  = r_state == ACC;
  assign out_valid = r_state == HOLD;
  assign acc_out   = r_acc;
  assign overflow  = r_ovf;
  assign count     = r_cnt;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= ACC;
      r_acc   <= '0;
      r_prod  <= '0;
      r_pv    <= 1'b0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
    end else if (clear) begin
      r_state <= ACC;
      r_acc   <= '0;
      r_pv    <= 1'b0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_pv <= w_beat;
      if (w_beat) r_prod <= w_ext;
      if (r_pv) begin
        r_acc <= w_next;
        if (w_sat) r_ovf <= 1'b1;
      end
      case (r_state)
        ACC:
          if (w_beat) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(LEN-1)) r_state <= DRAIN;
          end
        DRAIN: r_state <= HOLD;
        HOLD:
          if (out_ready) begin
            r_state <= ACC;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
          end
        default: r_state <= ACC;
      endcase
    end
endmodule

// File: tb/tb_mac_accum_signed_8bit.sv
// tb_mac_accum_signed_8bit: directed checks of the MAC at ACC_W=24 and ACC_W=16.
module tb_mac_accum_signed_8bit;
  logic clk = 1'b0, rst = 1'b1, clear = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic signed [7:0] a = '0, b = '0;
  logic in_ready24, out_valid24, overflow24, in_ready16, out_valid16, overflow16;
  logic signed [23:0] acc24;
  logic signed [15:0] acc16;
  logic [3:0] count24, count16;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  mac_accum_signed_8bit u24 (
    .clk(clk), .rst(rst), .clear(clear), .a(a), .b(b), .in_valid(in_valid),
    .in_ready(in_ready24), .acc_out(acc24), .out_valid(out_valid24), .out_ready(out_ready),
    .overflow(overflow24), .count(count24)
  );

  mac_accum_signed_8bit #(.ACC_W(16)) u16 (
    .clk(clk), .rst(rst), .clear(clear), .a(a), .b(b), .in_valid(in_valid),
    .in_ready(in_ready16), .acc_out(acc16), .out_valid(out_valid16), .out_ready(out_ready),
    .overflow(overflow16), .count(count16)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic signed [7:0] x, input logic signed [7:0] y);
    a = x;
    b = y;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic frame(input logic signed [7:0] x, input logic signed [7:0] y);
    for (int i = 0; i < 8; i++) beat(x, y);
  endtask

  initial begin
    tick();
    tick();
    chk("rst_in_ready", in_ready24, 1);
    chk("rst_out_valid", out_valid24, 0);
    chk("rst_count", count24, 0);
    chk("rst_acc", acc24, 0);
    chk("rst_overflow", overflow24, 0);
    rst = 1'b0;
    beat(1, 1);
    beat(1, 1);
    beat(1, 1);
    chk("pre_rst_count", count24, 3);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_count", count24, 0);
    chk("async_rst_in_ready", in_ready24, 1);
    chk("async_rst_out_valid", out_valid24, 0);
    tick();
    rst = 1'b0;

    out_ready = 1'b1;
    frame(3, 4);
    chk("basic_count", count24, 8);
    chk("basic_lat_valid_low", out_valid24, 0);
    chk("basic_drain_in_ready", in_ready24, 0);
    tick();
    chk("basic_valid", out_valid24, 1);
    chk("basic_acc", acc24, 96);
    chk("basic_overflow", overflow24, 0);
    chk("basic_hold_in_ready", in_ready24, 0);
    tick();
    chk("basic_after_valid", out_valid24, 0);
    chk("basic_after_count", count24, 0);
    chk("basic_after_in_ready", in_ready24, 1);

    beat(-128, 127);
    beat(127, 127);
    beat(-1, -1);
    beat(0, 55);
    beat(-128, -128);
    beat(5, -7);
    beat(-50, 2);
    beat(10, 10);
    tick();
    chk("mixed_valid", out_valid24, 1);
    chk("mixed_acc24", acc24, 16223);
    chk("mixed_acc16", acc16, 16223);
    tick();

    out_ready = 1'b0;
    frame(2, 2);
    tick();
    a = 9;
    b = 9;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", out_valid24, 1);
      chk("bp_acc", acc24, 32);
      chk("bp_in_ready", in_ready24, 0);
      chk("bp_count", count24, 8);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_release_in_ready", in_ready24, 1);
    chk("bp_release_acc", acc24, 0);
    frame(1, 1);
    tick();
    chk("bp_next_acc", acc24, 8);
    tick();

    frame(-128, -128);
    tick();
    chk("satp_acc16", acc16, 32767);
    chk("satp_ovf16", overflow16, 1);
    chk("satp_acc24", acc24, 131072);
    chk("satp_ovf24", overflow24, 0);
    tick();
    chk("satp_ovf16_cleared", overflow16, 0);
    frame(-128, 127);
    tick();
    chk("satn_acc16", acc16, -32768);
    chk("satn_ovf16", overflow16, 1);
    chk("satn_acc24", acc24, -130048);
    tick();
    chk("satn_ovf16_cleared", overflow16, 0);

    beat(100, 100);
    beat(100, 100);
    beat(100, 100);
    chk("clr_pre_count", count24, 3);
    clear = 1'b1;
    a = 5;
    b = 5;
    in_valid = 1'b1;
    tick();
    clear = 1'b0;
    in_valid = 1'b0;
    chk("clr_count", count24, 0);
    chk("clr_acc", acc24, 0);
    tick();
    chk("clr_stage1_dropped", acc24, 0);
    chk("clr_count_hold", count24, 0);
    frame(1, 1);
    tick();
    chk("clr_next_valid", out_valid24, 1);
    chk("clr_next_acc", acc24, 8);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mac_accum_signed_8bit.md
Name: mac_accum_signed_8bit

Overview:
- Downstream consumer of the 8-bit signed multiplier (mult_signed_8bit: a, b -> 16-bit signed product).
- Accepts a stream of signed 8-bit operand pairs through a valid/ready handshake and registers each product.
- Accumulates LEN products into a saturating signed accumulator, then presents the frame sum on an output valid/ready handshake.
- Used as the dot-product / FIR-tap accumulation stage behind the multiplier.

Parameters:
- LEN, 8, products per frame; must be >= 1.
- ACC_W, 24, accumulator and result width in bits; must be >= 16.
- CNT_W, 4, beat-counter width; must satisfy 2^CNT_W > LEN.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous frame abort; priority over every other input except rst.
- a  input  8  signed operand A.
- b  input  8  signed operand B.
- in_valid  input  1  a/b valid this cycle.
- in_ready  output  1  block accepts a/b this cycle.
- acc_out  output  ACC_W  signed frame sum.
- out_valid  output  1  acc_out holds a completed frame.
- out_ready  input  1  consumer takes acc_out.
- overflow  output  1  sticky; saturation occurred in the current or presented frame.
- count  output  CNT_W  beats accepted in the current frame.

Behaviour:
- Reset, asynchronous and active-high: state=ACC, acc_out=0, out_valid=0, in_ready=1, overflow=0, count=0, product-stage valid=0.
- Datapath: the instantiated mult_signed_8bit product is sign-extended to ACC_W, then added.
- Accept: a beat is accepted when in_valid && in_ready.
  - Cycle T: the product is registered (stage 1).
  - Cycle T+1: the registered product is added into the accumulator (stage 2).
- Saturation: each add saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - Later adds continue from the saturated value.
  - Any saturating add sets overflow=1 until the next frame starts.
- State ACC: in_ready=1, out_valid=0.
  - count increments on each accepted beat.
  - When the LEN-th beat is accepted, go to DRAIN.
- State DRAIN (1 cycle): in_ready=0; the last product is added; go to HOLD.
- State HOLD: out_valid=1, in_ready=0; acc_out, overflow and count are stable.
  - in_valid is ignored.
  - When out_ready=1, return to ACC and clear acc_out, count and overflow to 0.
  - A new beat can be accepted in the cycle after the out handshake.
- Latency: LEN-th beat accepted at cycle T gives out_valid=1 from T+2.
- Throughput: LEN beats per LEN+2 cycles with out_ready held high.
- LEN=1: go from ACC straight to DRAIN on the first accept.
- clear=1 in any state, on the next edge:
  - state=ACC; acc_out=0, count=0, overflow=0.
  - The stage-1 product is discarded; out_valid drops.
  - A beat presented in the same cycle as clear is not accepted.
- acc_out in ACC/DRAIN shows the running partial sum; it is only meaningful while out_valid=1.
- Reset mid-frame takes effect immediately, without waiting for the clock edge; all partial state is lost.

Test Plan:
- Reset mid-frame: assert rst asynchronously after 3 beats -> outputs go to their reset values immediately (in_ready=1, count=0, out_valid=0), without waiting for a clock edge.
- Basic frame: 8 beats of a=3, b=4 on consecutive cycles, out_ready=1 -> out_valid high 2 cycles after the 8th accept, acc_out=96, overflow=0.
- Mixed signs: (-128,127), (127,127), (-1,-1), (0,55), (-128,-128), (5,-7), (-50,2), (10,10) -> acc_out=16223.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid.
  - Required: acc_out stays stable, in_ready=0, and in_valid beats are not counted.
  - Then raise out_ready: the next frame of 8 x (1,1) gives 8.
- Saturation with ACC_W=16:
  - 8 x (-128,-128) -> acc_out=32767, overflow=1.
  - 8 x (-128,127) -> acc_out=-32768, overflow=1.
  - overflow returns to 0 after the out handshake.
- Clear: 3 beats of (100,100), then pulse clear -> count=0, acc_out=0; a following 8 x (1,1) frame gives acc_out=8.
